ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of Clock only.
REQ-002 Parameter NUM_REGS, default 16, SHALL set the general-register count (legal range 2..16).
REQ-003 Parameter CONTINUOUS, default 0, SHALL select the mode: 0 = single instruction per Run; 1 = fetch the next instruction immediately after completion.
REQ-004 Clock  in  1  system clock.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Run  in  1  start request, sampled in IDLE.
REQ-007 MemReady  in  1  memory read data valid; qualifies leaving T1.
REQ-008 IR  in  32  datapath IR output; valid from T3 onward; fields: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
REQ-009 PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, HIin, LOin  out  1 each  datapath strobes.
REQ-010 ALUop  out  5  ALU operation code.
REQ-011 Rout, Rin  out  NUM_REGS each  one-hot register-out and register-in selects.
REQ-012 Done  out  1  final execute cycle of an instruction.
REQ-013 Halted, Fault  out  1 each  sticky status flags.
REQ-014 State  out  4  current state: IDLE=0, T0..T6=1..7, HALT=8, FAULT=9.

Function
REQ-015 Outputs SHALL be Moore: a combinational function of the registered state and of IR only; every output not listed for a state SHALL be 0.
REQ-016 IDLE SHALL go to T0 when Run=1; otherwise it SHALL stay in IDLE.
REQ-017 T0 SHALL assert PCout, MARin, IncPC and Zin, then go to T1.
REQ-018 T1 SHALL assert Zlowout, PCin, Read and MDRin.
REQ-019 T1 SHALL go to T2 only when MemReady=1; otherwise it SHALL hold T1 with the same outputs.
REQ-020 T2 SHALL assert MDRout and IRin, then go to T3.
REQ-021 T3 SHALL decode IR: opcode 0x00-0x0E = ALU3; 0x0F (mul) or 0x10 (div) = MULDIV; 0x1B = halt; any other opcode = illegal.
REQ-022 An ALU3 or MULDIV instruction with Ra, Rb or Rc >= NUM_REGS SHALL be treated as illegal.
REQ-023 For a legal ALU3 or MULDIV instruction, T3 SHALL assert Rout[Rb] and Yin, then go to T4.
REQ-024 For halt, T3 outputs SHALL all be 0 and the next state SHALL be HALT.
REQ-025 For an illegal instruction, T3 outputs SHALL all be 0 and the next state SHALL be FAULT.
REQ-026 T4 SHALL assert Rout[Rc], Zin and ALUop=opcode, then go to T5.
REQ-027 For ALU3, T5 SHALL assert Zlowout, Rin[Ra] and Done.
REQ-028 For MULDIV, T5 SHALL assert Zlowout and LOin, then go to T6.
REQ-029 T6 SHALL assert Zhighout, HIin and Done.
REQ-030 After Done, the next state SHALL be IDLE when CONTINUOUS=0 and T0 when CONTINUOUS=1; Run SHALL be ignored outside IDLE.
REQ-031 HALT SHALL hold Halted=1 and FAULT SHALL hold Fault=1; both states SHALL persist, ignoring Run and MemReady, until Reset.
REQ-032 Rout and Rin SHALL never have more than one bit set, and SHALL never both be nonzero in the same cycle.

Reset
REQ-033 Reset=1 at a rising edge SHALL force IDLE from any state, including mid-T1 stall, HALT and FAULT.
REQ-034 In IDLE every output SHALL be 0, including Halted, Fault and State.
REQ-035 Reset SHALL take priority over Run and MemReady.

Verification
REQ-036 Reset asserted for 2 cycles -> State=0 and all outputs 0; Run held 0 -> block stays in IDLE.
REQ-037 IR=0x28918000, one-cycle Run pulse, MemReady=1 -> T0..T5 in 6 consecutive cycles; T3 Rout=0x0004; T4 Rout=0x0008 and ALUop=0x05; T5 Rin=0x0002 and Done=1; then IDLE.
REQ-038 MemReady=0 for the first 3 cycles of T1 -> T1 lasts 4 cycles with Read=MDRin=1 throughout, then T2.
REQ-039 IR=0x78118000 (mul R2,R3) -> T5 asserts Zlowout and LOin; T6 asserts Zhighout, HIin and Done; total latency 7 cycles.
REQ-040 IR=0xF8000000, or NUM_REGS=8 with Rb=9 -> FAULT one cycle after T3 with Fault=1; a later Run pulse has no effect; Reset -> IDLE.
REQ-041 CONTINUOUS=1 with IR=0xD8000000 (halt) -> HALT with Halted=1; Reset asserted during T4 of a prior ALU3 instruction -> IDLE on the next edge with all outputs 0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Hard-wired control sequencer for a single-bus datapath. It fetches one
//   instruction (T0..T2), decodes it in T3, and executes a 3-register ALU op
//   (T4..T5) or a mul/div (T4..T6). A halt opcode parks the block in HALT, and
//   an illegal opcode or register index parks it in FAULT. Both are left only
//   through Reset.
//
// Ports
//   Clock, Reset      : clock, synchronous active-high reset
//   Run               : start request, honoured only in IDLE
//   MemReady          : memory read data valid, releases the T1 stall
//   IR[31:0]          : instruction register (opcode, Ra, Rb, Rc fields)
//   PCout .. LOin     : one-bit datapath strobes
//   ALUop[4:0]        : ALU operation code (T4 only)
//   Rout, Rin         : one-hot register read / write selects
//   Done              : last execute cycle of an instruction
//   Halted, Fault     : status flags, high while in HALT / FAULT
//   State[3:0]        : IDLE=0, T0..T6=1..7, HALT=8, FAULT=9
module ctrl_sequencer #(
   parameter int NUM_REGS   = 16,
   parameter int CONTINUOUS = 0
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Run,
   input  logic                MemReady,
   input  logic [31:0]         IR,
   output logic                PCout,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                MDRout,
   output logic                MARin,
   output logic                Zin,
   output logic                PCin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                IncPC,
   output logic                Read,
   output logic                HIin,
   output logic                LOin,
   output logic [4:0]          ALUop,
   output logic [NUM_REGS-1:0] Rout,
   output logic [NUM_REGS-1:0] Rin,
   output logic                Done,
   output logic                Halted,
   output logic                Fault,
   output logic [3:0]          State
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_HALT  = 4'd8,
      S_FAULT = 4'd9
   } state_t;

   localparam logic [4:0] REG_LIMIT = 5'(NUM_REGS);
   // Where an instruction goes once its Done cycle is over.
   localparam state_t DONE_NEXT = (CONTINUOUS != 0) ? S_T0 : S_IDLE;

   state_t     state;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_alu3, is_muldiv, is_halt, regs_ok, legal;
   logic       unused_ir_bits;

   assign opcode = IR[31:27];
   assign ra     = IR[26:23];
   assign rb     = IR[22:19];
   assign rc     = IR[18:15];
   assign unused_ir_bits = ^IR[14:0];

   assign is_alu3   = (opcode <= 5'h0E);
   assign is_muldiv = (opcode == 5'h0F) || (opcode == 5'h10);
   assign is_halt   = (opcode == 5'h1B);
   // Register fields must address an implemented register.
   assign regs_ok   = ({1'b0, ra} < REG_LIMIT) && ({1'b0, rb} < REG_LIMIT) &&
                      ({1'b0, rc} < REG_LIMIT);
   assign legal     = (is_alu3 || is_muldiv) && regs_ok;

   // Shifting past the top bit yields zero, so out-of-range indices select nothing.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
      return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (Run) state <= S_T0;
            S_T0:    state <= S_T1;
            S_T1:    if (MemReady) state <= S_T2;
            S_T2:    state <= S_T3;
            S_T3:    state <= legal ? S_T4 : (is_halt ? S_HALT : S_FAULT);
            S_T4:    state <= S_T5;
            S_T5:    state <= is_muldiv ? S_T6 : DONE_NEXT;
            S_T6:    state <= DONE_NEXT;
            S_HALT:  state <= S_HALT;
            S_FAULT: state <= S_FAULT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Moore decode of the state register (and IR from T3 on).
   always_comb begin
      PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
      MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
      Yin = 1'b0; IncPC = 1'b0; Read = 1'b0; HIin = 1'b0; LOin = 1'b0;
      ALUop = 5'd0;
      Rout = '0;
      Rin = '0;
      Done = 1'b0;
      Halted = 1'b0;
      Fault = 1'b0;
      case (state)
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            // Halt and illegal instructions leave every strobe low here.
            if (legal) begin
               Rout = onehot(rb);
               Yin  = 1'b1;
            end
         end
         S_T4: begin
            Rout  = onehot(rc);
            Zin   = 1'b1;
            ALUop = opcode;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (is_muldiv) begin
               LOin = 1'b1;
            end else begin
               Rin  = onehot(ra);
               Done = 1'b1;
            end
         end
         S_T6: begin
            Zhighout = 1'b1; HIin = 1'b1; Done = 1'b1;
         end
         S_HALT:  Halted = 1'b1;
         S_FAULT: Fault = 1'b1;
         default: ;
      endcase
   end

   assign State = state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer
//   Three sequencers share Clock, Reset, MemReady and IR, each with its own
//   Run: u0 (16 regs, single), u1 (8 regs, single), u2 (16 regs, continuous).
//   Stimulus pushes hand-computed per-cycle snapshots into a per-instance
//   queue; a negedge monitor pops one entry for every cycle in which an
//   instance shows any nonzero output.
module tb_ctrl_sequencer;

   typedef struct packed {
      logic [3:0]  st;
      logic [13:0] stb;   // PCout,Zlowout,Zhighout,MDRout,MARin,Zin,PCin,MDRin,IRin,Yin,IncPC,Read,HIin,LOin
      logic [4:0]  alu;
      logic [15:0] rout;
      logic [15:0] rin;
      logic [2:0]  flg;   // Done,Halted,Fault
   } snap_t;

   localparam logic [13:0] M_PCOUT = 14'h2000, M_ZLOW = 14'h1000, M_ZHIGH = 14'h0800,
                           M_MDROUT = 14'h0400, M_MARIN = 14'h0200, M_ZIN = 14'h0100,
                           M_PCIN = 14'h0080, M_MDRIN = 14'h0040, M_IRIN = 14'h0020,
                           M_YIN = 14'h0010, M_INCPC = 14'h0008, M_READ = 14'h0004,
                           M_HIIN = 14'h0002, M_LOIN = 14'h0001;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        MemReady = 1'b1;
   logic [2:0]  run = 3'b000;
   logic [31:0] IR = 32'h0;
   logic        mon_en = 1'b0;

   logic [13:0] stb0, stb1, stb2;
   logic [4:0]  alu0, alu1, alu2;
   logic [15:0] ro0, ri0, ro2, ri2;
   logic [7:0]  ro1, ri1;
   logic [2:0]  fl0, fl1, fl2;
   logic [3:0]  st0, st1, st2;
   snap_t       s0, s1, s2;

   snap_t q[3][$];
   int tests = 0;
   int fails = 0;

   always #5 Clock = ~Clock;

   ctrl_sequencer #(.NUM_REGS(16), .CONTINUOUS(0)) u0 (
      .Clock(Clock), .Reset(Reset), .Run(run[0]), .MemReady(MemReady), .IR(IR),
      .PCout(stb0[13]), .Zlowout(stb0[12]), .Zhighout(stb0[11]), .MDRout(stb0[10]),
      .MARin(stb0[9]), .Zin(stb0[8]), .PCin(stb0[7]), .MDRin(stb0[6]), .IRin(stb0[5]),
      .Yin(stb0[4]), .IncPC(stb0[3]), .Read(stb0[2]), .HIin(stb0[1]), .LOin(stb0[0]),
      .ALUop(alu0), .Rout(ro0), .Rin(ri0), .Done(fl0[2]), .Halted(fl0[1]),
      .Fault(fl0[0]), .State(st0));

   ctrl_sequencer #(.NUM_REGS(8), .CONTINUOUS(0)) u1 (
      .Clock(Clock), .Reset(Reset), .Run(run[1]), .MemReady(MemReady), .IR(IR),
      .PCout(stb1[13]), .Zlowout(stb1[12]), .Zhighout(stb1[11]), .MDRout(stb1[10]),
      .MARin(stb1[9]), .Zin(stb1[8]), .PCin(stb1[7]), .MDRin(stb1[6]), .IRin(stb1[5]),
      .Yin(stb1[4]), .IncPC(stb1[3]), .Read(stb1[2]), .HIin(stb1[1]), .LOin(stb1[0]),
      .ALUop(alu1), .Rout(ro1), .Rin(ri1), .Done(fl1[2]), .Halted(fl1[1]),
      .Fault(fl1[0]), .State(st1));

   ctrl_sequencer #(.NUM_REGS(16), .CONTINUOUS(1)) u2 (
      .Clock(Clock), .Reset(Reset), .Run(run[2]), .MemReady(MemReady), .IR(IR),
      .PCout(stb2[13]), .Zlowout(stb2[12]), .Zhighout(stb2[11]), .MDRout(stb2[10]),
      .MARin(stb2[9]), .Zin(stb2[8]), .PCin(stb2[7]), .MDRin(stb2[6]), .IRin(stb2[5]),
      .Yin(stb2[4]), .IncPC(stb2[3]), .Read(stb2[2]), .HIin(stb2[1]), .LOin(stb2[0]),
      .ALUop(alu2), .Rout(ro2), .Rin(ri2), .Done(fl2[2]), .Halted(fl2[1]),
      .Fault(fl2[0]), .State(st2));

   always_comb begin
      s0 = {st0, stb0, alu0, ro0, ri0, fl0};
      s1 = {st1, stb1, alu1, 8'h00, ro1, 8'h00, ri1, fl1};
      s2 = {st2, stb2, alu2, ro2, ri2, fl2};
   end

   function automatic snap_t mk(input logic [3:0] st, input logic [13:0] stb,
                                input logic [4:0] alu, input logic [15:0] rout,
                                input logic [15:0] rin, input logic [2:0] flg);
      return {st, stb, alu, rout, rin, flg};
   endfunction

   task automatic chk(input string nm, input snap_t a, input snap_t e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got st=%0d stb=%h alu=%h rout=%h rin=%h flg=%b, want st=%0d stb=%h alu=%h rout=%h rin=%h flg=%b",
                  nm, a.st, a.stb, a.alu, a.rout, a.rin, a.flg,
                  e.st, e.stb, e.alu, e.rout, e.rin, e.flg);
      end
   endtask

   task automatic mon(input int k, input snap_t a);
      snap_t e;
      if (a != '0) begin
         if (q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL u%0d_unexpected: got st=%0d stb=%h rout=%h rin=%h flg=%b, want no activity",
                     k, a.st, a.stb, a.rout, a.rin, a.flg);
         end else begin
            e = q[k].pop_front();
            chk($sformatf("u%0d_st%0d", k, e.st), a, e);
         end
      end
   endtask

   always @(negedge Clock) begin
      if (mon_en) begin
         mon(0, s0);
         mon(1, s1);
         mon(2, s2);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic run_pulse(input int k);
      run[k] = 1'b1;
      cyc(1);
      run[k] = 1'b0;
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      tests++;
      if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
         fails++;
         $display("FAIL %s_drain: pending u0=%0d u1=%0d u2=%0d, want 0",
                  nm, q[0].size(), q[1].size(), q[2].size());
         for (int i = 0; i < 3; i++) q[i].delete();
      end
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_u0"}, s0, '0);
      chk({nm, "_u1"}, s1, '0);
      chk({nm, "_u2"}, s2, '0);
   endtask

   task automatic push_fetch(input int k, input int t1_cycles);
      q[k].push_back(mk(4'd1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'h0, 16'h0, 16'h0, 3'b000));
      for (int i = 0; i < t1_cycles; i++)
         q[k].push_back(mk(4'd2, M_ZLOW | M_PCIN | M_READ | M_MDRIN, 5'h0, 16'h0, 16'h0, 3'b000));
      q[k].push_back(mk(4'd3, M_MDROUT | M_IRIN, 5'h0, 16'h0, 16'h0, 3'b000));
   endtask

   task automatic push_alu3(input int k, input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                            input logic [4:0] op, input logic [15:0] ra_oh);
      q[k].push_back(mk(4'd4, M_YIN, 5'h0, rb_oh, 16'h0, 3'b000));
      q[k].push_back(mk(4'd5, M_ZIN, op, rc_oh, 16'h0, 3'b000));
      q[k].push_back(mk(4'd6, M_ZLOW, 5'h0, 16'h0, ra_oh, 3'b100));
   endtask

   task automatic push_muldiv(input int k, input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                              input logic [4:0] op);
      q[k].push_back(mk(4'd4, M_YIN, 5'h0, rb_oh, 16'h0, 3'b000));
      q[k].push_back(mk(4'd5, M_ZIN, op, rc_oh, 16'h0, 3'b000));
      q[k].push_back(mk(4'd6, M_ZLOW | M_LOIN, 5'h0, 16'h0, 16'h0, 3'b000));
      q[k].push_back(mk(4'd7, M_ZHIGH | M_HIIN, 5'h0, 16'h0, 16'h0, 3'b100));
   endtask

   // Instruction that ends in a sticky state: four cycles parked there, with a
   // Run pulse and MemReady low that must be ignored, then Reset.
   task automatic sticky(input string nm, input int k, input logic [31:0] ir, input snap_t e);
      IR = ir;
      push_fetch(k, 1);
      q[k].push_back(mk(4'd4, 14'h0, 5'h0, 16'h0, 16'h0, 3'b000));
      for (int i = 0; i < 4; i++) q[k].push_back(e);
      run_pulse(k);
      cyc(4);
      run[k] = 1'b1;
      MemReady = 1'b0;
      cyc(1);
      run[k] = 1'b0;
      cyc(2);
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;
      MemReady = 1'b1;
      drain(nm, 1);
      check_idle({nm, "_reset"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for two edges, then idle with Run low.
      cyc(2);
      Reset = 1'b0;
      mon_en = 1'b1;
      check_idle("reset");
      cyc(3);
      check_idle("idle_hold");

      // add-type ALU3: op 5, Ra=1, Rb=2, Rc=3.
      IR = 32'h28918000;
      push_fetch(0, 1);
      push_alu3(0, 16'h0004, 16'h0008, 5'h05, 16'h0002);
      run_pulse(0);
      drain("alu3", 12);
      check_idle("alu3_end");

      // Memory stall: T1 held for four cycles. op 0, all regs R0.
      IR = 32'h00000000;
      MemReady = 1'b0;
      push_fetch(0, 4);
      push_alu3(0, 16'h0001, 16'h0001, 5'h00, 16'h0001);
      run_pulse(0);
      cyc(4);
      MemReady = 1'b1;
      drain("stall", 12);
      check_idle("stall_end");

      // Rb=9 is legal with 16 registers.
      IR = 32'h28C98000;
      push_fetch(0, 1);
      push_alu3(0, 16'h0200, 16'h0008, 5'h05, 16'h0002);
      run_pulse(0);
      drain("rb9_16", 12);

      // mul R0, R2, R3.
      IR = 32'h78118000;
      push_fetch(0, 1);
      push_muldiv(0, 16'h0004, 16'h0008, 5'h0F);
      run_pulse(0);
      drain("mul", 12);
      check_idle("mul_end");

      // div, all regs R0.
      IR = 32'h80000000;
      push_fetch(0, 1);
      push_muldiv(0, 16'h0001, 16'h0001, 5'h10);
      run_pulse(0);
      drain("div", 12);

      // Illegal opcode 0x1F.
      sticky("illegal_op", 0, 32'hF8000000, mk(4'd9, 14'h0, 5'h0, 16'h0, 16'h0, 3'b001));

      // 8 registers: top register R7 is usable.
      IR = 32'h0B838000;
      push_fetch(1, 1);
      push_alu3(1, 16'h0001, 16'h0080, 5'h01, 16'h0080);
      run_pulse(1);
      drain("r7_8regs", 12);
      check_idle("r7_end");

      // 8 registers: Rb=9 is illegal.
      sticky("rb9_8regs", 1, 32'h28C98000, mk(4'd9, 14'h0, 5'h0, 16'h0, 16'h0, 3'b001));

      // Continuous: ALU3 refetches immediately; Reset lands in the second T4.
      IR = 32'h28918000;
      push_fetch(2, 1);
      push_alu3(2, 16'h0004, 16'h0008, 5'h05, 16'h0002);
      push_fetch(2, 1);
      q[2].push_back(mk(4'd4, M_YIN, 5'h0, 16'h0004, 16'h0, 3'b000));
      q[2].push_back(mk(4'd5, M_ZIN, 5'h05, 16'h0008, 16'h0, 3'b000));
      run_pulse(2);
      cyc(10);
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;
      drain("cont_reset_t4", 1);
      check_idle("cont_reset_t4");

      // Continuous: halt.
      sticky("halt", 2, 32'hD8000000, mk(4'd8, 14'h0, 5'h0, 16'h0, 16'h0, 3'b010));

      cyc(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
